// File: rtl/boolean_preimage_finder_pkg.sv
// Shared types and constants for the boolean preimage finder and its
// truth-table evaluator.
package boolean_pkg;

   localparam int NUM_IN = 4;
   localparam int TT_W   = 2 ** NUM_IN;
   localparam int CNT_W  = NUM_IN + 1;

   localparam logic [TT_W-1:0]   DEFAULT_TT = 16'hFC00;
   localparam logic [NUM_IN-1:0] LAST_IDX   = '1;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      EMIT,
      DONE
   } state_t;

endpackage

// File: rtl/boolean_preimage_finder_truth_table_eval.sv
// Combinational lookup of a 4-input boolean function stored as a truth table;
// index bit order is {A,B,C,D} with A as the MSB.
module truth_table_eval
   import boolean_pkg::*;
#(
   parameter logic [TT_W-1:0] TRUTH_TABLE = DEFAULT_TT
)
(
   input  logic [NUM_IN-1:0] idx,
   output logic              f
);

   assign f = TRUTH_TABLE[idx];

endmodule

// File: rtl/boolean_preimage_finder.sv
// Walks all 16 input combinations and streams out, over a valid/ready port,
// every combination whose function value equals the requested target.
module boolean_preimage_finder
   import boolean_pkg::*;
#(
   parameter logic [TT_W-1:0] TRUTH_TABLE = DEFAULT_TT
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              target,
   input  logic              abort,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NUM_IN-1:0] out_abcd,
   output logic              done,
   output logic [CNT_W-1:0]  match_count
);

   state_t              r_state;
   logic [NUM_IN-1:0]   r_idx;
   logic                r_tgt;
   logic [NUM_IN-1:0]   r_out_abcd;
   logic [CNT_W-1:0]    r_match_count;

   state_t              w_state_next;
   logic                w_f;
   logic                w_hit;
   logic                w_last;
   logic                w_handshake;
   logic                w_accept;
   logic                w_idx_inc;
   logic                w_load_abcd;
   logic                w_count_inc;

   truth_table_eval #(
      .TRUTH_TABLE (TRUTH_TABLE)
   ) u_eval (
      .idx (r_idx),
      .f   (w_f)
   );

   assign w_hit       = (w_f == r_tgt);
   assign w_last      = (r_idx == LAST_IDX);
   assign w_handshake = out_valid & out_ready;

   // NOTE: every signal driven here gets a default first so no path leaves
   // it unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_idx_inc    = 1'b0;
      w_load_abcd  = 1'b0;
      w_count_inc  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               w_state_next = IDLE;
            end else if (w_hit) begin
               w_load_abcd  = 1'b1;
               w_state_next = EMIT;
            end else if (w_last) begin
               w_state_next = DONE;
            end else begin
               w_idx_inc = 1'b1;
            end
         end
         EMIT: begin
            // Abort takes priority over a handshake in the same cycle.
            if (abort) begin
               w_state_next = IDLE;
            end else if (w_handshake) begin
               w_count_inc = 1'b1;
               if (w_last) begin
                  w_state_next = DONE;
               end else begin
                  w_idx_inc    = 1'b1;
                  w_state_next = SCAN;
               end
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx         <= '0;
         r_tgt         <= 1'b0;
         r_out_abcd    <= '0;
         r_match_count <= '0;
      end else begin
         if (w_accept) begin
            r_tgt         <= target;
            r_idx         <= '0;
            r_match_count <= '0;
         end else if (w_idx_inc) begin
            r_idx <= r_idx + NUM_IN'(1);
         end
         if (w_load_abcd) begin
            r_out_abcd <= r_idx;
         end
         if (w_count_inc) begin
            r_match_count <= r_match_count + CNT_W'(1);
         end
      end
   end

   // Status outputs decode directly from the registered state.
   assign busy        = (r_state != IDLE);
   assign out_valid   = (r_state == EMIT);
   assign done        = (r_state == DONE);
   assign out_abcd    = r_out_abcd;
   assign match_count = r_match_count;

endmodule

// File: tb/tb_boolean_preimage_finder.sv
// Randomised and directed bench for boolean_preimage_finder across four truth
// tables, checked against a list-of-preimages reference model.
module tb_boolean_preimage_finder;

   localparam logic [15:0] TT0 = 16'hFC00;
   localparam logic [15:0] TT1 = 16'h0000;
   localparam logic [15:0] TT2 = 16'hFFFF;
   localparam logic [15:0] TT3 = 16'hA5C3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] start;
   logic       target;
   logic       abort;
   logic       out_ready;
   logic [3:0] busy;
   logic [3:0] valid;
   logic [3:0] done;
   logic [3:0] abcd [4];
   logic [4:0] mc   [4];

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   boolean_preimage_finder #(.TRUTH_TABLE(TT0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .target(target), .abort(abort),
      .busy(busy[0]), .out_valid(valid[0]), .out_ready(out_ready),
      .out_abcd(abcd[0]), .done(done[0]), .match_count(mc[0]));
   boolean_preimage_finder #(.TRUTH_TABLE(TT1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .target(target), .abort(abort),
      .busy(busy[1]), .out_valid(valid[1]), .out_ready(out_ready),
      .out_abcd(abcd[1]), .done(done[1]), .match_count(mc[1]));
   boolean_preimage_finder #(.TRUTH_TABLE(TT2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .target(target), .abort(abort),
      .busy(busy[2]), .out_valid(valid[2]), .out_ready(out_ready),
      .out_abcd(abcd[2]), .done(done[2]), .match_count(mc[2]));
   boolean_preimage_finder #(.TRUTH_TABLE(TT3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start[3]), .target(target), .abort(abort),
      .busy(busy[3]), .out_valid(valid[3]), .out_ready(out_ready),
      .out_abcd(abcd[3]), .done(done[3]), .match_count(mc[3]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic tt_bit(input int sel, input int i);
      logic [15:0] t;
      case (sel)
         0:       t = TT0;
         1:       t = TT1;
         2:       t = TT2;
         default: t = TT3;
      endcase
      return t[i];
   endfunction

   task automatic check_all_zero(input string tag, input int sel);
      check({tag, "_busy"},  32'(busy[sel]),  0);
      check({tag, "_valid"}, 32'(valid[sel]), 0);
      check({tag, "_abcd"},  32'(abcd[sel]),  0);
      check({tag, "_done"},  32'(done[sel]),  0);
      check({tag, "_mc"},    32'(mc[sel]),    0);
   endtask

   // One full scan: expected emits are every index whose table bit equals the
   // target, in ascending order; done lands 17 + matches + stall cycles after start.
   task automatic run_scan(input string tag, input int sel, input logic tgt,
                           input int stall_pct, input int first_stall, input int poke_at);
      int   exp_q[$];
      int   got_q[$];
      int   cyc;
      int   stalls;
      int   stall_left;
      bit   stalled;
      logic [3:0] held;
      for (int i = 0; i < 16; i++) if (tt_bit(sel, i) == tgt) exp_q.push_back(i);
      stall_left = first_stall;
      stalled = 0;
      held = '0;
      stalls = 0;
      @(negedge clk);
      start[sel] = 1'b1;
      target = tgt;
      @(negedge clk);
      start[sel] = 1'b0;
      cyc = 1;
      while (cyc < 300) begin
         if (done[sel]) break;
         start[sel] = (cyc == poke_at);
         target     = (cyc == poke_at) ? ~tgt : tgt;
         if (valid[sel] && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = ($urandom_range(99) >= stall_pct);
         end
         if (valid[sel]) begin
            if (stalled) check({tag, "_hold"}, 32'(abcd[sel]), 32'(held));
            if (out_ready) begin
               got_q.push_back(int'(abcd[sel]));
               stalled = 0;
            end else begin
               stalls++;
               stalled = 1;
               held = abcd[sel];
            end
         end
         @(negedge clk);
         cyc++;
      end
      start[sel] = 1'b0;
      target = tgt;
      check({tag, "_done_cycle"}, 32'(cyc), 32'(17 + exp_q.size() + stalls));
      check({tag, "_busy_at_done"}, 32'(busy[sel]), 1);
      check({tag, "_mc"}, 32'(mc[sel]), 32'(exp_q.size()));
      check({tag, "_emit_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_emit"}, 32'(got_q[i]), 32'(exp_q[i]));
      @(negedge clk);
      check({tag, "_busy_after"}, 32'(busy[sel]), 0);
      check({tag, "_done_after"}, 32'(done[sel]), 0);
      check({tag, "_mc_hold"}, 32'(mc[sel]), 32'(exp_q.size()));
      out_ready = 1'b1;
   endtask

   initial begin
      int nvalid;
      int cyc;
      bit seen_done;
      rst = 1'b1;
      start = '0;
      target = 1'b0;
      abort = 1'b0;
      out_ready = 1'b1;
      #12;
      for (int s = 0; s < 4; s++) check_all_zero("reset", s);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_scan("def_t1",     0, 1'b1, 0, 0, 0);
      run_scan("def_t0",     0, 1'b0, 0, 0, 0);
      run_scan("def_stall5", 0, 1'b1, 0, 5, 0);
      run_scan("zero_t1",    1, 1'b1, 0, 0, 0);
      run_scan("ones_t1",    2, 1'b1, 0, 0, 0);
      run_scan("busy_start", 0, 1'b1, 0, 0, 6);

      for (int r = 0; r < 8; r++) begin
         run_scan("rand", int'($urandom_range(3)), 1'($urandom_range(1)), 30, 0,
                  int'($urandom_range(25)));
      end

      // Abort on the third presented match, with ready high in the same cycle.
      @(negedge clk);
      start[0] = 1'b1;
      target = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      out_ready = 1'b1;
      nvalid = 0;
      cyc = 0;
      while (nvalid < 3 && cyc < 100) begin
         if (valid[0]) nvalid++;
         if (nvalid == 3) abort = 1'b1;
         @(negedge clk);
         cyc++;
      end
      abort = 1'b0;
      check("abort_reached", 32'(nvalid), 3);
      check("abort_busy",  32'(busy[0]),  0);
      check("abort_valid", 32'(valid[0]), 0);
      check("abort_mc",    32'(mc[0]),    2);
      seen_done = 0;
      for (int i = 0; i < 20; i++) begin
         if (done[0] || busy[0]) seen_done = 1;
         @(negedge clk);
      end
      check("abort_no_done", 32'(seen_done), 0);
      check("abort_mc_hold", 32'(mc[0]), 2);

      // Asynchronous reset mid-scan, applied between clock edges.
      start[0] = 1'b1;
      target = 1'b0;
      @(negedge clk);
      start[0] = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk);
      check("pre_rst_busy", 32'(busy[0]), 1);
      #1 rst = 1'b1;
      #1;
      check_all_zero("async_rst", 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_scan("post_rst", 3, 1'b1, 20, 2, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/boolean_preimage_finder.md
Name: boolean_preimage_finder

Overview:
- Sequential inverse of the team's 4-input switch-level boolean function block. Given a target output value, it enumerates every input combination (A,B,C,D) and streams out those that produce the target.
- Function under test is a 16-bit truth-table parameter. The default encodes Y = A·(B+C) + A·C·D, which reduces to A·(B+C).
- Sits beside the combinational function blocks as a self-checking and preimage source, e.g. for feeding directed vectors into benches or exercising downstream logic.

Parameters:
- TRUTH_TABLE, 16'hFC00, bit i = f(i), where i = {A,B,C,D} and A is the MSB. Default sets bits 10..15 only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request. Sampled only in IDLE.
- target  input  1  required f value. Captured on an accepted start.
- abort  input  1  synchronous cancel. Effective in any non-IDLE state.
- busy  output  1  high in SCAN, EMIT and DONE.
- out_valid  output  1  a matching combination is presented.
- out_ready  input  1  downstream accepts the presented combination.
- out_abcd  output  4  the combination, {A,B,C,D}.
- done  output  1  one-cycle pulse at the end of a completed scan.
- match_count  output  5  number of matches emitted (0..16). Holds its value until the next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, out_valid=0, out_abcd=0, done=0, match_count=0; idx=0, tgt=0.
- Only one clock domain, clk. Reset deassertion is used as-is; no internal synchronizer.
- State IDLE:
  - On start=1: tgt<=target, idx<=0, match_count<=0, next state SCAN.
  - Otherwise remain in IDLE.
- State SCAN: evaluates hit = (TRUTH_TABLE[idx] == tgt) for one idx per cycle.
  - hit=1: out_abcd<=idx, next state EMIT. out_valid rises on the following cycle.
  - hit=0 and idx==15: next state DONE.
  - hit=0 and idx<15: idx<=idx+1, stay in SCAN.
- State EMIT:
  - out_valid=1; out_abcd is held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: match_count<=match_count+1, out_valid<=0.
  - After the handshake: go to DONE if idx==15, otherwise idx<=idx+1 and return to SCAN.
- State DONE: done=1 for exactly this one cycle, then IDLE. busy drops in the same cycle the FSM enters IDLE.
- Cost per index with out_ready held high: 1 cycle for a non-match, 2 cycles for a match.
- Latency: the first SCAN cycle is the cycle after start is accepted.
- Boundary conditions:
  - start while busy is ignored; tgt and idx are unchanged.
  - abort wins over every other event in the same cycle, including a handshake. Next state is IDLE with out_valid=0 and no done pulse. match_count keeps its partial value.
  - idx is 4 bits and never wraps past 15; termination is checked before the increment.
  - match_count is 5 bits, so the value 16 is representable (e.g. an all-ones table with target=1).
  - If no index matches: no out_valid ever rises; done is still pulsed and match_count=0.
  - rst asserted mid-scan or mid-EMIT returns all outputs to reset values immediately, independent of clk.

Decomposition:
- Shared package boolean_pkg holds:
  - the state enum {IDLE, SCAN, EMIT, DONE};
  - constant DEFAULT_TT = 16'hFC00;
  - constant NUM_IN = 4.
- One natural sub-module, truth_table_eval: combinational, input idx[3:0], output f = TRUTH_TABLE[idx]. It is parameterised with TRUTH_TABLE so it can be cross-checked against the switch-level function block.

Test Plan:
- Default table, target=1, out_ready=1, start at cycle 0:
  - out_abcd sequence is 10,11,12,13,14,15;
  - done pulses at cycle 23 with match_count=6.
- Default table, target=0, out_ready=1:
  - emits 0..9 in order;
  - done at cycle 27 with match_count=10.
- target=1, out_ready low for 5 cycles at the first EMIT:
  - out_valid stays 1 and out_abcd stays 10 throughout;
  - the scan resumes after ready rises;
  - final match_count=6.
- TRUTH_TABLE=16'h0000, target=1: no out_valid ever; done at cycle 17 with match_count=0.
- TRUTH_TABLE=16'hFFFF, target=1: 16 emits; match_count=16 (no overflow).
- Interruptions:
  - abort during the third EMIT of the default/target=1 scan: returns to IDLE next cycle, no done, match_count=2.
  - rst pulse mid-scan: all outputs return to 0 asynchronously.
  - start pulsed while busy: no effect.
